// File: rtl/pattern_gen_pkg.sv
// Shared encodings for the pattern generator: stream modes and FSM states.
package pattern_gen_pkg;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_DEC   = 2'd1;
    localparam logic [1:0] MODE_PRBS  = 2'd2;
    localparam logic [1:0] MODE_CONST = 2'd3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/pattern_gen_lfsr_next.sv
// Combinational next-word function of a Fibonacci LFSR that shifts left,
// feeding the parity of the tapped bits back into the LSB.
module lfsr_next #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] next
);

    logic [WIDTH-1:0] tapped;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_tap
            assign tapped[gi] = cur[gi] & TAPS[gi];
        end
    endgenerate

    assign next = {cur[WIDTH-2:0], ^tapped};

endmodule

// File: rtl/pattern_gen.sv
// Test-data source: emits INC/DEC/PRBS/CONST words on a valid/ready stream,
// either as finite bursts (with last/done) or continuously until stopped.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               CNT_W = 16,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] step,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    state_t           state_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] prbs_next;
    logic [WIDTH-1:0] seed_eff;
    logic [1:0]       mode_reg;
    logic [WIDTH-1:0] step_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic             finite_reg;
    logic             last_reg;
    logic             done_reg;
    logic             xfer;

    assign xfer = (state_reg == S_RUN) && out_ready;

    lfsr_next #(.WIDTH(WIDTH), .TAPS(TAPS)) u_lfsr (
        .cur  (data_reg),
        .next (prbs_next)
    );

    // An all-zero LFSR would lock up, so a zero PRBS seed is promoted to 1.
    assign seed_eff = (mode == MODE_PRBS && seed == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : seed;

    always_comb begin
        data_next = data_reg;
        if (xfer) begin
            case (mode_reg)
                MODE_INC:  data_next = data_reg + step_reg;
                MODE_DEC:  data_next = data_reg - step_reg;
                MODE_PRBS: data_next = prbs_next;
                default:   data_next = data_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            data_reg      <= '0;
            mode_reg      <= MODE_INC;
            step_reg      <= '0;
            remaining_reg <= '0;
            finite_reg    <= 1'b0;
            last_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_reg     <= S_RUN;
                        data_reg      <= seed_eff;
                        mode_reg      <= mode;
                        step_reg      <= step;
                        remaining_reg <= burst_len;
                        finite_reg    <= (burst_len != '0);
                        last_reg      <= (burst_len == CNT_W'(1));
                    end
                end
                S_RUN: begin
                    data_reg <= data_next;
                    if (stop || (xfer && last_reg)) begin
                        state_reg <= S_IDLE;
                        last_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else if (xfer && finite_reg) begin
                        // last flags the beat that will be presented once this one is taken
                        remaining_reg <= remaining_reg - CNT_W'(1);
                        last_reg      <= (remaining_reg == CNT_W'(2));
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign data_out  = data_reg;
    assign out_valid = (state_reg == S_RUN);
    assign out_last  = last_reg;
    assign busy      = (state_reg == S_RUN);
    assign done      = done_reg;

endmodule
